// File: rtl/mv_pkg.sv
// mv_pkg: shared definitions for the matrix-vector job sequencer.
//   - seq_state_e       : sequencer FSM states
//   - ARRAY_SIZE_DEF    : default PE row count (write-out drain length)
//   - K_ACCUM_DEPTH_DEF : default maximum accumulation depth per tile
//   - CYCLE_W           : width of the PE phase counter (cycle_num)
package mv_pkg;

  localparam int ARRAY_SIZE_DEF    = 32;
  localparam int K_ACCUM_DEPTH_DEF = 64;
  localparam int CYCLE_W           = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mv_addr_gen.sv
// mv_addr_gen: weight/vector SRAM read-address counters.
// Latches the job bases and depth, loads w_base + tile*k / v_base at the
// start of every tile, and steps both addresses once per accumulation cycle.
// All arithmetic wraps modulo 2^ADDR_W.
// Ports:
//   clk, srst                 clock, asynchronous active-high reset
//   cfg_load                  job accepted: latch bases/depth, load tile 0
//   cfg_w_base, cfg_v_base    job base addresses
//   cfg_k                     job accumulation depth
//   tile_load, tile           start of a later tile (tile = new tile index)
//   step                      advance both addresses by one
//   clear                     job finished/aborted: park addresses at 0
//   sram_w_addr, sram_v_addr  registered read addresses
module mv_addr_gen
  import mv_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_v_base,
  input  logic [6:0]        cfg_k,
  input  logic              tile_load,
  input  logic [3:0]        tile,
  input  logic              step,
  input  logic              clear,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [ADDR_W-1:0] sram_v_addr
);

  logic [ADDR_W-1:0] w_base_r;
  logic [ADDR_W-1:0] v_base_r;
  logic [ADDR_W-1:0] k_r;
  logic [ADDR_W-1:0] tile_off_s;

  // Offset of the current tile's weight block, truncated to the address width.
  assign tile_off_s = ADDR_W'(tile) * k_r;

  // Base latches and address counters; a new job takes precedence over stepping.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      w_base_r    <= '0;
      v_base_r    <= '0;
      k_r         <= '0;
      sram_w_addr <= '0;
      sram_v_addr <= '0;
    end else if (cfg_load) begin
      w_base_r    <= cfg_w_base;
      v_base_r    <= cfg_v_base;
      k_r         <= ADDR_W'(cfg_k);
      sram_w_addr <= cfg_w_base;
      sram_v_addr <= cfg_v_base;
    end else if (tile_load) begin
      sram_w_addr <= w_base_r + tile_off_s;
      sram_v_addr <= v_base_r;
    end else if (step) begin
      sram_w_addr <= sram_w_addr + ADDR_W'(1);
      sram_v_addr <= sram_v_addr + ADDR_W'(1);
    end else if (clear) begin
      sram_w_addr <= '0;
      sram_v_addr <= '0;
    end else begin
      sram_w_addr <= sram_w_addr;
      sram_v_addr <= sram_v_addr;
    end
  end

endmodule

// File: rtl/mv_job_sequencer.sv
// mv_job_sequencer: sequences a multi-tile matrix-vector job on a PE array.
// Per tile: k accumulation cycles (addresses stepping), ARRAY_SIZE drain
// cycles (addresses held), then a one-cycle gap before the next tile or a
// one-cycle DONE state after the last one. All outputs are registered.
// Optional feature: define MV_SEQ_PERF_CNT_EN to add perf_busy_cycles
// (saturating busy-cycle count) and perf_jobs (wrapping done count).
// Ports:
//   clk, srst                   clock, asynchronous active-high reset
//   start, abort                job request / cancel
//   cfg_k, cfg_tiles            depth (1..K_ACCUM_DEPTH), tiles (1..MAX_TILES)
//   cfg_w_base, cfg_v_base      SRAM base addresses
//   sram_w_addr, sram_v_addr    SRAM read addresses
//   alu_start, cycle_num        PE run enable and phase counter
//   o_base                      output SRAM base of current tile
//   busy, done, aborted, cfg_err  status (last three are one-cycle pulses)
module mv_job_sequencer
  import mv_pkg::*;
#(
  parameter int ARRAY_SIZE    = ARRAY_SIZE_DEF,
  parameter int K_ACCUM_DEPTH = K_ACCUM_DEPTH_DEF,
  parameter int ADDR_W        = 10,
  parameter int MAX_TILES     = 8
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               start,
  input  logic               abort,
  input  logic [6:0]         cfg_k,
  input  logic [3:0]         cfg_tiles,
  input  logic [ADDR_W-1:0]  cfg_w_base,
  input  logic [ADDR_W-1:0]  cfg_v_base,
  output logic [ADDR_W-1:0]  sram_w_addr,
  output logic [ADDR_W-1:0]  sram_v_addr,
  output logic               alu_start,
  output logic [CYCLE_W-1:0] cycle_num,
  output logic [ADDR_W-1:0]  o_base,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               cfg_err
`ifdef MV_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_busy_cycles,
  output logic [15:0]        perf_jobs
`endif
);

  localparam logic [6:0] K_MAX = 7'(K_ACCUM_DEPTH);
  localparam logic [3:0] T_MAX = 4'(MAX_TILES);

  seq_state_e         state_r, state_nx;
  logic [6:0]         k_r;
  logic [3:0]         tiles_r, tile_r, tile_nx;
  logic [CYCLE_W-1:0] cycle_nx;
  logic               alu_nx, busy_nx, done_nx, aborted_nx, cfg_err_nx;
  logic               cfg_ok_s, accum_end_s, drain_end_s, last_tile_s;
  logic               cfg_load_s, tile_load_s, step_s, clear_s;

  assign cfg_ok_s    = (cfg_k != 7'd0) && (cfg_k <= K_MAX) &&
                       (cfg_tiles != 4'd0) && (cfg_tiles <= T_MAX);
  assign accum_end_s = (cycle_num == CYCLE_W'(k_r));
  assign drain_end_s = (cycle_num == (CYCLE_W'(k_r) + CYCLE_W'(ARRAY_SIZE)));
  assign last_tile_s = (tile_r == (tiles_r - 4'd1));

  // FSM state register.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state and next-output logic; abort is checked first in busy states
  // so it wins over every other transition, including the end of the job.
  always_comb begin
    state_nx    = state_r;
    tile_nx     = tile_r;
    cycle_nx    = cycle_num;
    alu_nx      = alu_start;
    busy_nx     = busy;
    done_nx     = 1'b0;
    aborted_nx  = 1'b0;
    cfg_err_nx  = 1'b0;
    cfg_load_s  = 1'b0;
    tile_load_s = 1'b0;
    step_s      = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && cfg_ok_s) begin
          state_nx   = ST_ACCUM;
          tile_nx    = 4'd0;
          cycle_nx   = CYCLE_W'(1);
          alu_nx     = 1'b1;
          busy_nx    = 1'b1;
          cfg_load_s = 1'b1;
        end else if (start) begin
          cfg_err_nx = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ACCUM, ST_DRAIN, ST_GAP: begin
        if (abort) begin
          state_nx   = ST_IDLE;
          cycle_nx   = '0;
          alu_nx     = 1'b0;
          busy_nx    = 1'b0;
          aborted_nx = 1'b1;
          clear_s    = 1'b1;
        end else if (state_r == ST_GAP) begin
          state_nx    = ST_ACCUM;
          cycle_nx    = CYCLE_W'(1);
          alu_nx      = 1'b1;
          tile_load_s = 1'b1;
        end else if (state_r == ST_ACCUM) begin
          cycle_nx = cycle_num + CYCLE_W'(1);
          if (accum_end_s) begin
            state_nx = ST_DRAIN;
          end else begin
            step_s = 1'b1;
          end
        end else if (drain_end_s) begin
          cycle_nx = '0;
          alu_nx   = 1'b0;
          if (last_tile_s) begin
            state_nx = ST_DONE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_GAP;
            tile_nx  = tile_r + 4'd1;
          end
        end else begin
          cycle_nx = cycle_num + CYCLE_W'(1);
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
        clear_s  = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
        cycle_nx = '0;
        alu_nx   = 1'b0;
        busy_nx  = 1'b0;
        clear_s  = 1'b1;
      end
    endcase
  end

  // Job configuration, tile index and registered outputs.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      k_r       <= 7'd0;
      tiles_r   <= 4'd0;
      tile_r    <= 4'd0;
      cycle_num <= '0;
      alu_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_err   <= 1'b0;
      o_base    <= '0;
    end else begin
      if (cfg_load_s) begin
        k_r     <= cfg_k;
        tiles_r <= cfg_tiles;
      end else begin
        k_r     <= k_r;
        tiles_r <= tiles_r;
      end
      // o_base only moves when the tile index does.
      if (tile_nx != tile_r) begin
        o_base <= ADDR_W'(tile_nx) * ADDR_W'(ARRAY_SIZE);
      end else begin
        o_base <= o_base;
      end
      tile_r    <= tile_nx;
      cycle_num <= cycle_nx;
      alu_start <= alu_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      aborted   <= aborted_nx;
      cfg_err   <= cfg_err_nx;
    end
  end

  mv_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .srst        (srst),
    .cfg_load    (cfg_load_s),
    .cfg_w_base  (cfg_w_base),
    .cfg_v_base  (cfg_v_base),
    .cfg_k       (cfg_k),
    .tile_load   (tile_load_s),
    .tile        (tile_r),
    .step        (step_s),
    .clear       (clear_s),
    .sram_w_addr (sram_w_addr),
    .sram_v_addr (sram_v_addr)
  );

`ifdef MV_SEQ_PERF_CNT_EN
  // Performance counters: busy cycles saturate, completed jobs wrap.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      perf_busy_cycles <= 32'd0;
      perf_jobs        <= 16'd0;
    end else begin
      if (busy && (perf_busy_cycles != 32'hFFFF_FFFF)) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end else begin
        perf_busy_cycles <= perf_busy_cycles;
      end
      if (done) begin
        perf_jobs <= perf_jobs + 16'd1;
      end else begin
        perf_jobs <= perf_jobs;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mv_job_sequencer.sv
// tb_mv_job_sequencer: directed + randomized bench for mv_job_sequencer.
// The expected per-cycle trace of a job is generated from the job rules
// (tile/accumulate/drain/gap arithmetic) and compared with the outputs.
module tb_mv_job_sequencer;

  localparam int A  = 32;
  localparam int KD = 64;
  localparam int AW = 10;
  localparam int MT = 8;
  localparam int AM = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          srst, start, abort;
  logic [6:0]    cfg_k;
  logic [3:0]    cfg_tiles;
  logic [AW-1:0] cfg_w_base, cfg_v_base, sram_w_addr, sram_v_addr, o_base;
  logic          alu_start, busy, done, aborted, cfg_err;
  logic [8:0]    cycle_num;
`ifdef MV_SEQ_PERF_CNT_EN
  logic [31:0]   perf_busy_cycles;
  logic [15:0]   perf_jobs;
`endif

  int checks = 0;
  int failures = 0;
  int jobs_done = 0;

  typedef struct {
    int alu; int cyc; int w; int v; int ob; int busy; int done; int addr_chk;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mv_job_sequencer #(
    .ARRAY_SIZE(A), .K_ACCUM_DEPTH(KD), .ADDR_W(AW), .MAX_TILES(MT)
  ) dut (
    .clk(clk), .srst(srst), .start(start), .abort(abort),
    .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
    .cfg_w_base(cfg_w_base), .cfg_v_base(cfg_v_base),
    .sram_w_addr(sram_w_addr), .sram_v_addr(sram_v_addr),
    .alu_start(alu_start), .cycle_num(cycle_num), .o_base(o_base),
    .busy(busy), .done(done), .aborted(aborted), .cfg_err(cfg_err)
`ifdef MV_SEQ_PERF_CNT_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_jobs(perf_jobs)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w"}, 32'(sram_w_addr), 32'd0);
    check({tag, "_v"}, 32'(sram_v_addr), 32'd0);
    check({tag, "_alu"}, 32'(alu_start), 32'd0);
    check({tag, "_cyc"}, 32'(cycle_num), 32'd0);
    check({tag, "_obase"}, 32'(o_base), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_aborted"}, 32'(aborted), 32'd0);
    check({tag, "_cfgerr"}, 32'(cfg_err), 32'd0);
  endtask

  task automatic set_cfg(input int k, input int tiles, input int wb, input int vb);
    cfg_k      = 7'(k);
    cfg_tiles  = 4'(tiles);
    cfg_w_base = AW'(wb);
    cfg_v_base = AW'(vb);
  endtask

  // Expected trace, one entry per cycle starting with the first ACCUM cycle.
  task automatic build(input int k, input int tiles, input int wb, input int vb);
    exp_q.delete();
    for (int t = 0; t < tiles; t++) begin
      for (int i = 1; i <= k; i++)
        exp_q.push_back('{1, i, (wb + t*k + i - 1) & AM, (vb + i - 1) & AM, (t*A) & AM, 1, 0, 1});
      for (int j = 1; j <= A; j++)
        exp_q.push_back('{1, k + j, (wb + t*k + k - 1) & AM, (vb + k - 1) & AM, (t*A) & AM, 1, 0, 1});
      if (t < tiles - 1)
        exp_q.push_back('{0, 0, 0, 0, ((t+1)*A) & AM, 1, 0, 0});
      else
        exp_q.push_back('{0, 0, 0, 0, (t*A) & AM, 0, 1, 0});
    end
  endtask

  // Runs one job; abort_idx >= 0 aborts on that trace cycle.
  task automatic run_job(input string tag, input int k, input int tiles, input int wb,
                         input int vb, input int abort_idx, input bit noise, input bit start_on_done);
    int done_at;
    exp_t e;
    done_at = -1;
    build(k, tiles, wb, vb);
    set_cfg(k, tiles, wb, vb);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (done === 1'b1 && done_at < 0) done_at = i + 1;
      check({tag, "_alu"}, 32'(alu_start), 32'(e.alu));
      check({tag, "_cyc"}, 32'(cycle_num), 32'(e.cyc));
      check({tag, "_obase"}, 32'(o_base), 32'(e.ob));
      check({tag, "_busy"}, 32'(busy), 32'(e.busy));
      check({tag, "_done"}, 32'(done), 32'(e.done));
      check({tag, "_aborted"}, 32'(aborted), 32'd0);
      check({tag, "_cfgerr"}, 32'(cfg_err), 32'd0);
      if (e.addr_chk != 0) begin
        check({tag, "_w"}, 32'(sram_w_addr), 32'(e.w));
        check({tag, "_v"}, 32'(sram_v_addr), 32'(e.v));
      end
      if (i == abort_idx) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check({tag, "_abort_alu"}, 32'(alu_start), 32'd0);
        check({tag, "_abort_cyc"}, 32'(cycle_num), 32'd0);
        check({tag, "_abort_pulse"}, 32'(aborted), 32'd1);
        check({tag, "_abort_done"}, 32'(done), 32'd0);
        check({tag, "_abort_busy"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_abort_pulse_end"}, 32'(aborted), 32'd0);
        check({tag, "_abort_done2"}, 32'(done), 32'd0);
        return;
      end
      // Starts outside IDLE carry random cfg and must leave the job untouched.
      if (e.done != 0) begin
        start = start_on_done;
        if (start_on_done) set_cfg(3, 1, 0, 0);
      end else if (noise) begin
        start      = ($urandom_range(0, 5) == 0);
        cfg_k      = 7'($urandom);
        cfg_tiles  = 4'($urandom);
        cfg_w_base = AW'($urandom);
        cfg_v_base = AW'($urandom);
      end
      tick();
      start = 1'b0;
    end
    check({tag, "_after_busy"}, 32'(busy), 32'd0);
    check({tag, "_after_alu"}, 32'(alu_start), 32'd0);
    check({tag, "_after_done"}, 32'(done), 32'd0);
    check({tag, "_after_cfgerr"}, 32'(cfg_err), 32'd0);
    check({tag, "_latency"}, 32'(done_at), 32'(tiles*(k + A) + (tiles - 1) + 1));
    jobs_done++;
    tick();
    check({tag, "_after_busy2"}, 32'(busy), 32'd0);
  endtask

  task automatic cfg_err_case(input string tag, input int k, input int tiles);
    set_cfg(k, tiles, 5, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_pulse"}, 32'(cfg_err), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_alu"}, 32'(alu_start), 32'd0);
    tick();
    check({tag, "_pulse_end"}, 32'(cfg_err), 32'd0);
    check({tag, "_busy2"}, 32'(busy), 32'd0);
  endtask

  initial begin
    srst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    tick();
    tick();
    check_all_zero("reset");
    srst = 1'b0;
    tick();
    check_all_zero("idle");

    // abort in IDLE is a no-op
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_pulse", 32'(aborted), 32'd0);
    check("abort_idle_busy", 32'(busy), 32'd0);

    cfg_err_case("cfg_k0", 0, 1);
    cfg_err_case("cfg_t9", 4, 9);
    cfg_err_case("cfg_k65", 65, 2);
    cfg_err_case("cfg_t0", 4, 0);

    run_job("k64", 64, 1, 0, 0, -1, 1'b0, 1'b0);
    run_job("k4t3", 4, 3, 100, 0, -1, 1'b0, 1'b0);
    run_job("wrap", 4, 1, 1022, 1021, -1, 1'b0, 1'b1);
    run_job("abort70", 64, 1, 0, 0, 69, 1'b0, 1'b0);
    run_job("post_abort", 2, 2, 7, 9, -1, 1'b0, 1'b0);
    run_job("abort_gap", 3, 2, 0, 0, 3 + A, 1'b0, 1'b0);
    run_job("abort_last", 5, 1, 0, 0, 5 + A - 1, 1'b0, 1'b0);

    // reset in the middle of ACCUM discards the job silently
    set_cfg(10, 2, 40, 50);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    srst = 1'b1;
    #1;
    check_all_zero("srst_mid");
    tick();
    srst = 1'b0;
    jobs_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("srst_rel_done", 32'(done), 32'd0);
      check("srst_rel_aborted", 32'(aborted), 32'd0);
      check("srst_rel_busy", 32'(busy), 32'd0);
      check("srst_rel_alu", 32'(alu_start), 32'd0);
    end

    for (int n = 0; n < 8; n++) begin
      run_job("rand", int'($urandom_range(1, KD)), int'($urandom_range(1, MT)),
              int'($urandom_range(0, AM)), int'($urandom_range(0, AM)), -1, 1'b1, 1'b0);
    end

`ifdef MV_SEQ_PERF_CNT_EN
    check("perf_jobs", 32'(perf_jobs), 32'(jobs_done));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mv_job_sequencer.md
MV_JOB_SEQUENCER -- requirements
Module: mv_job_sequencer

Interface
REQ-001 Parameter ARRAY_SIZE, default 32: PE rows, which equals the write-out drain length in cycles.
REQ-002 Parameter K_ACCUM_DEPTH, default 64: maximum accumulation depth per tile.
REQ-003 Parameter ADDR_W, default 10: width of the SRAM address ports.
REQ-004 Parameter MAX_TILES, default 8: maximum number of output tiles per job.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 srst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle job request.
REQ-008 abort  in  1  cancels the current job.
REQ-009 cfg_k  in  7  accumulation depth; legal range 1..K_ACCUM_DEPTH.
REQ-010 cfg_tiles  in  4  tile count; legal range 1..MAX_TILES.
REQ-011 cfg_w_base, cfg_v_base  in  ADDR_W  base addresses of the weight and vector SRAMs.
REQ-012 sram_w_addr, sram_v_addr  out  ADDR_W  read addresses.
REQ-013 alu_start  out  1  PE run enable.
REQ-014 cycle_num  out  9  PE phase counter.
REQ-015 o_base  out  ADDR_W  outcome SRAM base address for the current tile (tile*ARRAY_SIZE).
REQ-016 busy  out  1  job in progress.
REQ-017 done, aborted, cfg_err  out  1  each a one-cycle status pulse.

Function
REQ-018 The FSM SHALL have exactly five states: IDLE, ACCUM, DRAIN, GAP and DONE.
REQ-019 In IDLE, a start with legal cfg SHALL latch cfg_k, cfg_tiles and both bases, set tile=0 and enter ACCUM on the next cycle.
REQ-020 In IDLE, a start with illegal cfg (cfg_k=0, cfg_k>K_ACCUM_DEPTH, cfg_tiles=0 or cfg_tiles>MAX_TILES) SHALL pulse cfg_err for one cycle and keep the FSM in IDLE.
REQ-021 A start in any state other than IDLE SHALL be ignored.
REQ-022 On the first ACCUM cycle: alu_start=1, cycle_num=1, sram_w_addr=w_base+tile*k, sram_v_addr=v_base.
REQ-023 Each ACCUM cycle SHALL increment cycle_num, sram_w_addr and sram_v_addr by 1.
REQ-024 ACCUM SHALL transition to DRAIN after the cycle on which cycle_num==k.
REQ-025 In DRAIN, cycle_num SHALL increment through k+1..k+ARRAY_SIZE, addresses SHALL hold and alu_start SHALL stay 1.
REQ-026 At cycle_num==k+ARRAY_SIZE with tile<tiles-1: enter GAP for exactly one cycle with alu_start=0 and cycle_num=0, increment tile, then return to ACCUM.
REQ-027 At cycle_num==k+ARRAY_SIZE with the last tile: enter DONE for one cycle, pulse done, alu_start=0, cycle_num=0, then go to IDLE.
REQ-028 busy SHALL be 1 in ACCUM, DRAIN and GAP, and 0 in IDLE and DONE.
REQ-029 A start that arrives on the DONE cycle SHALL be ignored.
REQ-030 abort in ACCUM, DRAIN or GAP SHALL force IDLE on the next edge: alu_start=0, cycle_num=0, aborted pulses, done does not pulse.
REQ-031 abort has priority over every transition on the same cycle, including the final-tile end of DRAIN.
REQ-032 abort in IDLE or DONE SHALL be a no-op.
REQ-033 Address arithmetic SHALL be modulo 2^ADDR_W (wrap-around, no saturation).
REQ-034 o_base SHALL be a registered value updated only on tile change.
REQ-035 Total job latency from start to done SHALL be tiles*(k+ARRAY_SIZE) + (tiles-1) + 1 cycles.

Reset
REQ-036 While srst is high, all outputs SHALL be 0 and the FSM SHALL be in IDLE.
REQ-037 Reset asserted mid-job SHALL discard the job with no done or aborted pulse.

Configuration
REQ-038 With MV_SEQ_PERF_CNT_EN defined, outputs perf_busy_cycles (32 bits, counts busy cycles and saturates at max) and perf_jobs (16 bits, counts done pulses and wraps) SHALL exist; both SHALL clear only on srst.
REQ-039 Without MV_SEQ_PERF_CNT_EN, those ports and counters SHALL be absent.

Structure
REQ-040 The shared package mv_pkg SHALL hold the FSM state enum, the default ARRAY_SIZE and K_ACCUM_DEPTH constants, and the cycle_num width.
REQ-041 The sub-module mv_addr_gen SHALL own the address counters and the tile*k base computation; the FSM SHALL remain in the top.

Verification
REQ-042 cfg_k=64, tiles=1, bases 0, start: alu_start high 96 cycles, w/v addr 0..63, done 97 cycles after start.
REQ-043 cfg_k=4, tiles=3, w_base=100: w_addr starts 100/104/108, one-cycle alu_start gap between tiles, o_base 0/32/64.
REQ-044 cfg_k=0, then cfg_tiles=9: cfg_err pulses each time, busy stays 0.
REQ-045 abort at DRAIN cycle_num=70 (k=64): next cycle alu_start=0, aborted=1, done=0; a fresh start is accepted afterward.
REQ-046 w_base=2^ADDR_W-2, k=4: w_addr sequence 1022, 1023, 0, 1.
REQ-047 srst asserted during ACCUM: all outputs 0 immediately, no status pulse after release.
